ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
- Sits directly behind the PS/2 byte receiver and sequences its raw scan-code byte stream (set 2) into key events.
- Tracks E0/F0 prefixes, Shift and Caps Lock state, and maps make codes to ASCII or command events.
- Buffers events in a small FIFO with a valid/ready output, consumed by the text-entry/display logic.
- Downstream logic sees one clean event per key press instead of raw prefix/make/break bytes.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed between a prefix byte and its follow-up byte before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- scan_byte  in  8  byte from the PS/2 receiver
- scan_valid  in  1  one-cycle strobe; scan_byte is valid in that cycle
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_kind  out  3  head event kind: CHAR=0, ENTER=1, BKSP=2, UP=3, DOWN=4
- ev_char  out  8  ASCII for CHAR; 8'h00 for all other kinds
- shift_held  out  1  either Shift key currently down
- caps_lock  out  1  Caps Lock toggle state
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- proto_err  out  1  sticky: a prefix timed out

Behaviour:
- Reset (rst==0): FSM to IDLE; FIFO emptied; shift/caps/caps_held/timer cleared; every output 0. scan_valid is ignored while in reset.
- FSM states:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(normal).
  - EXT: F0 -> EXT_BRK; any other byte -> make(ext), then IDLE.
  - BRK: any byte -> break(normal), then IDLE.
  - EXT_BRK: any byte -> break(ext), then IDLE.
- make(normal):
  - 12/59 set lshift/rshift.
  - 58 toggles caps_lock only if caps_held==0, then sets caps_held; typematic repeats do not re-toggle.
  - 5A -> ENTER; 66 -> BKSP.
  - Letters/digits/space emit CHAR through the decoder.
  - Unknown codes: no event.
- make(ext): 75 -> UP; 72 -> DOWN; all others no event.
- break(normal): 12/59 clear the matching shift bit; 58 clears caps_held. No events.
- break(ext): no effect.
- ASCII mapping:
  - Letters: uppercase iff shift_held XOR caps_lock.
  - Digits: shift_held selects the symbols !@#$%^&*() for 1..9,0; caps_lock does not affect digits.
  - Space 29 -> 8'h20 regardless of modifiers.
- Modifier timing: an update from a byte takes effect in the cycle after that byte, so a make code uses the modifier state registered before it.
- Latency: the event is written to the FIFO on the edge that ends the scan_valid cycle. If the FIFO was empty, ev_valid rises in the next cycle.
- FIFO:
  - First-word fall-through; ev_kind and ev_char are driven from the head whenever ev_valid==1.
  - Pop on ev_valid & ev_ready.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped, overflow is set, and FIFO contents are unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap; a separate count (log2+1 bits) distinguishes full from empty.
- Timeout:
  - The timer clears on every scan_valid and counts while in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1: FSM -> IDLE and proto_err is set. The pending byte is lost; no event is emitted.
  - If scan_valid coincides with expiry, the byte wins: it is processed in the current state and no error is flagged.
- Sticky flags: overflow and proto_err clear only on reset.

Decomposition:
- Package ps2_key_pkg:
  - ev_kind_t enum.
  - Scan-code constants: E0, F0, LSHIFT, RSHIFT, CAPS, ENTER, BKSP, UP, DOWN, SPACE.
  - FSM state_t.
- Sub-module ps2_scan_to_ascii:
  - Purely combinational.
  - Inputs: code, shift, caps. Outputs: ascii[7:0], is_char.
- The FIFO stays inline.

Test Plan:
- 1C -> CHAR 8'h61 ('a'), ev_valid one cycle after the strobe. With 12,1C,F0,12,1C -> CHAR 8'h41 then CHAR 8'h61; shift_held is 0 at end.
- 58,F0,58,58,58,F0,58,1C -> caps_lock toggles once per press (final 0 after two presses). Check: one press then 1C -> 8'h41; shift+caps then 1C -> 8'h61.
- E0,75 -> UP; E0,72 -> DOWN; E0,F0,75 -> no event; 5A -> ENTER; 66 -> BKSP, each with ev_char 8'h00.
- ev_ready=0, send FIFO_DEPTH+1 codes of 1C -> exactly 8 events queued, overflow=1. Then ev_ready=1 drains 8 CHAR 8'h61 and ev_valid drops.
- E0 followed by silence for TIMEOUT_CYCLES (bench uses 16) -> proto_err=1, FSM in IDLE; a following 1C emits CHAR 'a'. Byte on the expiry cycle -> proto_err stays 0.
- Send F0, then pulse rst=0 for one cycle, then 1C -> CHAR 'a'; all outputs 0 during reset; push and pop in the same cycle while full keeps count at FIFO_DEPTH.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared event kinds, set-2 scan-code constants and FSM states
package ps2_key_pkg;
  typedef enum logic [2:0] {
    EV_CHAR  = 3'd0,
    EV_ENTER = 3'd1,
    EV_BKSP  = 3'd2,
    EV_UP    = 3'd3,
    EV_DOWN  = 3'd4
  } ev_kind_t;
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_SPACE  = 8'h29;
endpackage

// File: rtl/ps2_scan_to_ascii.sv
// ps2_scan_to_ascii: combinational set-2 make code to ASCII for letters, digits and space
module ps2_scan_to_ascii import ps2_key_pkg::*; (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       is_char
);
  logic [7:0] base, sym;
  logic       letter;
  always_comb begin
    base   = 8'h00;
    sym    = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: {letter, base} = {1'b1, "a"};
      8'h32: {letter, base} = {1'b1, "b"};
      8'h21: {letter, base} = {1'b1, "c"};
      8'h23: {letter, base} = {1'b1, "d"};
      8'h24: {letter, base} = {1'b1, "e"};
      8'h2B: {letter, base} = {1'b1, "f"};
      8'h34: {letter, base} = {1'b1, "g"};
      8'h33: {letter, base} = {1'b1, "h"};
      8'h43: {letter, base} = {1'b1, "i"};
      8'h3B: {letter, base} = {1'b1, "j"};
      8'h42: {letter, base} = {1'b1, "k"};
      8'h4B: {letter, base} = {1'b1, "l"};
      8'h3A: {letter, base} = {1'b1, "m"};
      8'h31: {letter, base} = {1'b1, "n"};
      8'h44: {letter, base} = {1'b1, "o"};
      8'h4D: {letter, base} = {1'b1, "p"};
      8'h15: {letter, base} = {1'b1, "q"};
      8'h2D: {letter, base} = {1'b1, "r"};
      8'h1B: {letter, base} = {1'b1, "s"};
      8'h2C: {letter, base} = {1'b1, "t"};
      8'h3C: {letter, base} = {1'b1, "u"};
      8'h2A: {letter, base} = {1'b1, "v"};
      8'h1D: {letter, base} = {1'b1, "w"};
      8'h22: {letter, base} = {1'b1, "x"};
      8'h35: {letter, base} = {1'b1, "y"};
      8'h1A: {letter, base} = {1'b1, "z"};
      8'h16: {base, sym} = {"1", "!"};
      8'h1E: {base, sym} = {"2", "@"};
      8'h26: {base, sym} = {"3", "#"};
      8'h25: {base, sym} = {"4", "$"};
      8'h2E: {base, sym} = {"5", "%"};
      8'h36: {base, sym} = {"6", "^"};
      8'h3D: {base, sym} = {"7", "&"};
      8'h3E: {base, sym} = {"8", "*"};
      8'h46: {base, sym} = {"9", "("};
      8'h45: {base, sym} = {"0", ")"};
      SC_SPACE: {base, sym} = {8'h20, 8'h20};
      default: ;
    endcase
    is_char = base != 8'h00;
    ascii   = letter ? ((shift ^ caps) ? base - 8'h20 : base) : (shift ? sym : base);
  end
endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: sequences PS/2 set-2 bytes into key events queued in a FWFT FIFO
module ps2_key_event_ctrl import ps2_key_pkg::*; #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_kind,
  output logic [7:0] ev_char,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow,
  output logic       proto_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t         state, state_nx;
  ev_kind_t       kind;
  logic [TW-1:0]  timer;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic [10:0]    mem [FIFO_DEPTH];
  logic [7:0]     ascii, ch;
  logic           lshift, rshift, caps_held, is_char;
  logic           make_n, make_e, brk_n, timeout, push, push_ok, pop, full;
  ps2_scan_to_ascii u_dec (.code(scan_byte), .shift(shift_held), .caps(caps_lock), .ascii(ascii), .is_char(is_char));
  assign shift_held = lshift | rshift;
  assign ev_valid   = count != '0;
  assign full       = count == (PW+1)'(FIFO_DEPTH);
  assign pop        = ev_valid & ev_ready;
  assign push_ok    = push & (~full | pop);
  assign {ev_kind, ev_char} = ev_valid ? mem[rd_ptr] : 11'd0;
  always_comb begin
    make_n   = scan_valid && state == S_IDLE && scan_byte != SC_E0 && scan_byte != SC_F0;
    make_e   = scan_valid && state == S_EXT && scan_byte != SC_F0;
    brk_n    = scan_valid && state == S_BRK;
    // a byte arriving on the expiry cycle takes priority over the timeout
    timeout  = !scan_valid && state != S_IDLE && timer == TW'(TIMEOUT_CYCLES - 1);
    state_nx = state;
    if (timeout) state_nx = S_IDLE;
    else if (scan_valid)
      case (state)
        S_IDLE:  state_nx = scan_byte == SC_E0 ? S_EXT : scan_byte == SC_F0 ? S_BRK : S_IDLE;
        S_EXT:   state_nx = scan_byte == SC_F0 ? S_EXT_BRK : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    kind = make_e ? (scan_byte == SC_UP ? EV_UP : EV_DOWN)
         : scan_byte == SC_ENTER ? EV_ENTER : scan_byte == SC_BKSP ? EV_BKSP : EV_CHAR;
    ch   = kind == EV_CHAR ? ascii : 8'h00;
    push = (make_n && (is_char || scan_byte == SC_ENTER || scan_byte == SC_BKSP))
        || (make_e && (scan_byte == SC_UP || scan_byte == SC_DOWN));
  end
  always_ff @(posedge clk)
    if (rst && push_ok) mem[wr_ptr] <= {kind, ch};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (scan_valid || state == S_IDLE || timeout) ? '0 : timer + 1'b1;
      if (make_n && scan_byte == SC_LSHIFT) lshift <= 1'b1;
      if (brk_n && scan_byte == SC_LSHIFT) lshift <= 1'b0;
      if (make_n && scan_byte == SC_RSHIFT) rshift <= 1'b1;
      if (brk_n && scan_byte == SC_RSHIFT) rshift <= 1'b0;
      // caps_held suppresses re-toggling on typematic repeats
      if (make_n && scan_byte == SC_CAPS) begin
        caps_held <= 1'b1;
        if (!caps_held) caps_lock <= ~caps_lock;
      end
      if (brk_n && scan_byte == SC_CAPS) caps_held <= 1'b0;
      if (timeout) proto_err <= 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed scoreboard bench for the PS/2 key event controller
module tb_ps2_key_event_ctrl;
  import ps2_key_pkg::*;
  localparam int DEPTH = 8;
  localparam int TO    = 16;
  logic       clk = 1'b0, rst = 1'b0, scan_valid = 1'b0, ev_ready = 1'b1;
  logic [7:0] scan_byte = 8'h00;
  logic       ev_valid, shift_held, caps_lock, overflow, proto_err;
  logic [2:0] ev_kind;
  logic [7:0] ev_char;
  logic [10:0] sb[$];
  logic [10:0] mon_exp;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_char(ev_char),
    .shift_held(shift_held), .caps_lock(caps_lock), .overflow(overflow), .proto_err(proto_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic expect_ev(input logic [2:0] k, input logic [7:0] c);
    sb.push_back({k, c});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    scan_byte  = b;
    scan_valid = 1'b1;
    idle(1);
    scan_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 64 && (sb.size() != 0 || ev_valid); i++) idle(1);
    idle(1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    chk({tag, "_ev_valid"}, 32'(ev_valid), 0);
  endtask
  always @(negedge clk)
    if (rst && ev_valid && ev_ready) begin
      chk("unexpected_event", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("event", 32'({ev_kind, ev_char}), 32'(mon_exp));
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    scan_byte  = 8'h1C;
    scan_valid = 1'b1;
    idle(3);
    scan_valid = 1'b0;
    chk("reset_outputs", 32'({ev_valid, ev_kind, ev_char, shift_held, caps_lock, overflow, proto_err}), 0);
    rst = 1'b1;
    idle(2);
    chk("post_reset_outputs", 32'({ev_valid, ev_kind, ev_char, shift_held, caps_lock, overflow, proto_err}), 0);
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    chk("latency_ev_valid", 32'(ev_valid), 1);
    drain("char_a");
    send(8'h12);
    expect_ev(EV_CHAR, "A");
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    chk("shift_released", 32'(shift_held), 0);
    drain("shift");
    send(8'h58);
    chk("caps_on", 32'(caps_lock), 1);
    expect_ev(EV_CHAR, "A");
    send(8'h1C);
    send(8'hF0);
    send(8'h58);
    send(8'h59);
    chk("rshift_held", 32'(shift_held), 1);
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    expect_ev(EV_CHAR, "!");
    send(8'h16);
    expect_ev(EV_CHAR, 8'h20);
    send(8'h29);
    send(8'hF0);
    send(8'h59);
    expect_ev(EV_CHAR, "1");
    send(8'h16);
    send(8'h58);
    chk("caps_second_press", 32'(caps_lock), 0);
    send(8'h58);
    send(8'h58);
    chk("caps_typematic", 32'(caps_lock), 0);
    send(8'hF0);
    send(8'h58);
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    drain("caps");
    send(8'hE0);
    expect_ev(EV_UP, 8'h00);
    send(8'h75);
    send(8'hE0);
    expect_ev(EV_DOWN, 8'h00);
    send(8'h72);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'h1C);
    send(8'h05);
    expect_ev(EV_ENTER, 8'h00);
    send(8'h5A);
    expect_ev(EV_BKSP, 8'h00);
    send(8'h66);
    drain("commands");
    send(8'hE0);
    idle(TO - 1);
    expect_ev(EV_UP, 8'h00);
    send(8'h75);
    chk("expiry_byte_no_err", 32'(proto_err), 0);
    drain("expiry_byte");
    send(8'hE0);
    idle(TO + 2);
    chk("timeout_proto_err", 32'(proto_err), 1);
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    drain("after_timeout");
    ev_ready = 1'b0;
    repeat (DEPTH) begin
      expect_ev(EV_CHAR, "a");
      send(8'h1C);
    end
    chk("full_no_overflow_yet", 32'(overflow), 0);
    send(8'h1C);
    chk("overflow_set", 32'(overflow), 1);
    chk("full_ev_valid", 32'(ev_valid), 1);
    ev_ready = 1'b1;
    expect_ev(EV_CHAR, "b");
    send(8'h32);
    ev_ready = 1'b0;
    idle(1);
    chk("full_head_kind", 32'(ev_kind), 32'(EV_CHAR));
    ev_ready = 1'b1;
    drain("overflow_drain");
    ev_ready = 1'b0;
    send(8'h58);
    send(8'h12);
    send(8'h1C);
    send(8'hF0);
    rst = 1'b0;
    sb.delete();
    idle(1);
    chk("mid_reset_outputs", 32'({ev_valid, ev_kind, ev_char, shift_held, caps_lock, overflow, proto_err}), 0);
    rst = 1'b1;
    ev_ready = 1'b1;
    expect_ev(EV_CHAR, "a");
    send(8'h1C);
    drain("after_mid_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
